// File: rtl/dmem_responder_pkg.sv
// ============================================================================
// Module      : dmem_responder_pkg
// Description : Shared address map, timer control bit positions and reset
//               constants for the data-memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_responder_pkg;

  localparam logic [31:0] RAM_BASE    = 32'h0000_0000;
  localparam logic [31:0] GPIO_OUT_A  = 32'h0000_0800;
  localparam logic [31:0] GPIO_IN_A   = 32'h0000_0804;
  localparam logic [31:0] TMR_COUNT_A = 32'h0000_0808;
  localparam logic [31:0] TMR_CTRL_A  = 32'h0000_080C;
  localparam logic [31:0] TMR_CMP_A   = 32'h0000_0810;

  localparam int TMR_EN_BIT   = 0;
  localparam int TMR_AR_BIT   = 1;
  localparam int TMR_FLAG_BIT = 2;
  localparam int TMR_IE_BIT   = 3;

  localparam logic [31:0] TMR_CMP_RST = 32'hFFFF_FFFF;

endpackage

`default_nettype wire

// File: rtl/dmem_timer.sv
// ============================================================================
// Module      : dmem_timer
// Description : Free-running compare timer with auto-reload, sticky flag and
//               registered interrupt output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_timer
  import dmem_responder_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_wr_count,
  input  logic        i_wr_ctrl,
  input  logic        i_wr_cmp,
  input  logic [31:0] i_wd,
  output logic [31:0] o_count,
  output logic [31:0] o_ctrl,
  output logic [31:0] o_cmp,
  output logic        o_irq
);

  logic [31:0] r_count;
  logic [31:0] r_cmp;
  logic        r_en;
  logic        r_ar;
  logic        r_flag;
  logic        r_ie;
  logic        r_irq;
  logic        w_match;
  logic [31:0] w_count_nxt;

  assign w_match = r_en && (r_count == r_cmp);

  // Priority: core write > auto-reload > increment.
  always_comb begin
    w_count_nxt = r_count;
    if (r_en)
      w_count_nxt = r_count + 32'd1;
    if (w_match && r_ar)
      w_count_nxt = '0;
    if (i_wr_count)
      w_count_nxt = i_wd;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
      r_cmp   <= TMR_CMP_RST;
      r_en    <= 1'b0;
      r_ar    <= 1'b0;
      r_flag  <= 1'b0;
      r_ie    <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_irq   <= r_flag & r_ie;
      if (i_wr_cmp)
        r_cmp <= i_wd;
      if (i_wr_ctrl) begin
        r_en <= i_wd[TMR_EN_BIT];
        r_ar <= i_wd[TMR_AR_BIT];
        r_ie <= i_wd[TMR_IE_BIT];
      end
      // A match on the same edge as write-1-to-clear keeps the flag set.
      if (w_match)
        r_flag <= 1'b1;
      else if (i_wr_ctrl && i_wd[TMR_FLAG_BIT])
        r_flag <= 1'b0;
    end
  end

  always_comb begin
    o_ctrl               = '0;
    o_ctrl[TMR_EN_BIT]   = r_en;
    o_ctrl[TMR_AR_BIT]   = r_ar;
    o_ctrl[TMR_FLAG_BIT] = r_flag;
    o_ctrl[TMR_IE_BIT]   = r_ie;
  end

  assign o_count = r_count;
  assign o_cmp   = r_cmp;
  assign o_irq   = r_irq;

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
// Module      : dmem_responder
// Description : Core data-memory slave: word RAM, GPIO and timer behind a
//               zero-latency combinational read port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int RAM_WORDS        = 64,
  parameter int GPIO_SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  input  logic        we,
  output logic [31:0] rd,
  input  logic [31:0] gpio_in,
  output logic [31:0] gpio_out,
  output logic        irq,
  output logic        bus_err
);

  localparam int AW = $clog2(RAM_WORDS);

  logic [31:0] r_ram [RAM_WORDS];
  logic [31:0] r_gpio_out;
  logic [31:0] r_sync [GPIO_SYNC_STAGES];
  logic        r_bus_err;

  logic [31:0] w_waddr;
  logic        w_ram_hit;
  logic        w_sel_gpo;
  logic        w_sel_gpi;
  logic        w_sel_cnt;
  logic        w_sel_ctrl;
  logic        w_sel_cmp;
  logic        w_writable;
  logic        w_ram_we;
  logic [31:0] w_tmr_count;
  logic [31:0] w_tmr_ctrl;
  logic [31:0] w_tmr_cmp;
  logic        w_unused;

  assign w_waddr    = {addr[31:2], 2'b00};
  assign w_ram_hit  = (addr[31:AW+2] == RAM_BASE[31:AW+2]);
  assign w_sel_gpo  = (w_waddr == GPIO_OUT_A);
  assign w_sel_gpi  = (w_waddr == GPIO_IN_A);
  assign w_sel_cnt  = (w_waddr == TMR_COUNT_A);
  assign w_sel_ctrl = (w_waddr == TMR_CTRL_A);
  assign w_sel_cmp  = (w_waddr == TMR_CMP_A);
  assign w_writable = w_ram_hit | w_sel_gpo | w_sel_cnt | w_sel_ctrl | w_sel_cmp;
  assign w_unused   = ^addr[1:0];

  // RAM is never cleared; writes landing while reset is held are dropped.
  assign w_ram_we = we & w_ram_hit & rst;

  always_ff @(posedge clk) begin
    if (w_ram_we)
      r_ram[addr[AW+1:2]] <= wd;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_gpio_out <= '0;
      r_bus_err  <= 1'b0;
      for (int i = 0; i < GPIO_SYNC_STAGES; i++)
        r_sync[i] <= '0;
    end else begin
      if (we && w_sel_gpo)
        r_gpio_out <= wd;
      r_bus_err <= we & ~w_writable;
      r_sync[0] <= gpio_in;
      for (int i = 1; i < GPIO_SYNC_STAGES; i++)
        r_sync[i] <= r_sync[i-1];
    end
  end

  dmem_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_wr_count (we & w_sel_cnt),
    .i_wr_ctrl  (we & w_sel_ctrl),
    .i_wr_cmp   (we & w_sel_cmp),
    .i_wd       (wd),
    .o_count    (w_tmr_count),
    .o_ctrl     (w_tmr_ctrl),
    .o_cmp      (w_tmr_cmp),
    .o_irq      (irq)
  );

  always_comb begin
    rd = '0;
    if (w_ram_hit)
      rd = r_ram[addr[AW+1:2]];
    else if (w_sel_gpo)
      rd = r_gpio_out;
    else if (w_sel_gpi)
      rd = r_sync[GPIO_SYNC_STAGES-1];
    else if (w_sel_cnt)
      rd = w_tmr_count;
    else if (w_sel_ctrl)
      rd = w_tmr_ctrl;
    else if (w_sel_cmp)
      rd = w_tmr_cmp;
  end

  assign gpio_out = r_gpio_out;
  assign bus_err  = r_bus_err;

endmodule

`default_nettype wire
